// File: rtl/sot_align_ctrl.sv
// sot_align_ctrl: supervises MXVFATS start-of-transfer frame aligners. It pulses
// per-channel aligner resets, waits for lock with a per-attempt timeout, retries
// the channels that did not lock and declares them failed once the retries run out.
// Optional feature macro SOT_AUTO_REALIGN_EN: when defined, channels lost while
// monitoring are realigned automatically; otherwise the block flags the loss
// through all_aligned_o and waits for start_i.
module sot_align_ctrl #(
  parameter int MXVFATS     = 24,
  parameter int RST_CYCLES  = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [MXVFATS-1:0] vfat_mask_i,
  input  logic [15:0]        timeout_cycles_i,
  input  logic [MXVFATS-1:0] sot_is_aligned_i,
  input  logic [MXVFATS-1:0] sot_unstable_i,
  output logic [MXVFATS-1:0] aligner_reset_o,
  output logic               all_aligned_o,
  output logic               busy_o,
  output logic [MXVFATS-1:0] fail_mask_o,
  output logic [7:0]         realign_cnt_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET     = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_MONITOR   = 2'd3
  } state_t;

  localparam logic [15:0] LP_RST_CYCLES  = 16'(RST_CYCLES);
  localparam logic [7:0]  LP_MAX_RETRIES = 8'(MAX_RETRIES);

  state_t             r_state;
  logic [MXVFATS-1:0] r_target;
  logic [MXVFATS-1:0] r_fail;
  logic [MXVFATS-1:0] r_aligner_reset;
  logic               r_all_aligned;
  logic               r_busy;
  logic [7:0]         r_realign_cnt;
  logic [7:0]         r_retry;
  logic [15:0]        r_pulse_cnt;
  logic [15:0]        r_tmo_cnt;

  logic [MXVFATS-1:0] w_unmasked;
  logic [MXVFATS-1:0] w_tgt_eff;
  logic [MXVFATS-1:0] w_unaligned;
  logic [MXVFATS-1:0] w_fail_next;
  logic [MXVFATS-1:0] w_lost;
  logic [MXVFATS-1:0] w_lost_after_fail;
  logic [15:0]        w_tmo_eff;
  logic               w_tmo_hit;
  logic [7:0]         w_realign_next;

  // Live target excludes masked and failed channels, so mask changes act next cycle.
  always_comb begin
    w_unmasked        = ~vfat_mask_i;
    w_tgt_eff         = r_target & w_unmasked & ~r_fail;
    w_unaligned       = w_tgt_eff & ~sot_is_aligned_i;
    w_fail_next       = r_fail | w_unaligned;
    w_lost            = w_unmasked & ~r_fail & (sot_unstable_i | ~sot_is_aligned_i);
    w_lost_after_fail = w_unmasked & ~w_fail_next & (sot_unstable_i | ~sot_is_aligned_i);
    w_tmo_eff         = (timeout_cycles_i == '0) ? 16'd1 : timeout_cycles_i;
    w_tmo_hit         = ({1'b0, r_tmo_cnt} + 17'd1) >= {1'b0, w_tmo_eff};
    w_realign_next    = (r_realign_cnt == 8'hFF) ? r_realign_cnt : r_realign_cnt + 8'd1;
  end

  // Alignment sequencer; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_state         <= ST_IDLE;
      r_target        <= '0;
      r_fail          <= '0;
      r_aligner_reset <= '1;
      r_all_aligned   <= 1'b0;
      r_busy          <= 1'b0;
      r_realign_cnt   <= '0;
      r_retry         <= '0;
      r_pulse_cnt     <= '0;
      r_tmo_cnt       <= '0;
    end else if (start_i || (r_state == ST_IDLE)) begin
      // Full realignment: leaving IDLE after reset and start_i from any state share this path.
      r_state         <= ST_RESET;
      r_target        <= w_unmasked;
      r_fail          <= '0;
      r_retry         <= '0;
      r_pulse_cnt     <= 16'd1;
      r_tmo_cnt       <= '0;
      r_aligner_reset <= w_unmasked;
      r_all_aligned   <= 1'b0;
      r_busy          <= 1'b1;
      r_realign_cnt   <= w_realign_next;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_pulse_cnt >= LP_RST_CYCLES) begin
            r_state         <= ST_WAIT_LOCK;
            r_aligner_reset <= '0;
            r_tmo_cnt       <= '0;
          end else begin
            r_aligner_reset <= w_tgt_eff;
            r_pulse_cnt     <= r_pulse_cnt + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_unaligned == '0) begin
            r_state       <= ST_MONITOR;
            r_all_aligned <= (w_lost == '0);
            r_busy        <= 1'b0;
          end else if (w_tmo_hit) begin
            if (r_retry >= LP_MAX_RETRIES) begin
              r_fail        <= w_fail_next;
              r_state       <= ST_MONITOR;
              r_all_aligned <= (w_lost_after_fail == '0);
              r_busy        <= 1'b0;
            end else begin
              r_retry         <= r_retry + 8'd1;
              r_target        <= w_unaligned;
              r_state         <= ST_RESET;
              r_pulse_cnt     <= 16'd1;
              r_aligner_reset <= w_unaligned;
              r_realign_cnt   <= w_realign_next;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        ST_MONITOR: begin
`ifdef SOT_AUTO_REALIGN_EN
          if (w_lost != '0) begin
            r_target        <= w_lost;
            r_retry         <= '0;
            r_state         <= ST_RESET;
            r_pulse_cnt     <= 16'd1;
            r_aligner_reset <= w_lost;
            r_realign_cnt   <= w_realign_next;
            r_all_aligned   <= 1'b0;
            r_busy          <= 1'b1;
          end else begin
            r_all_aligned <= 1'b1;
          end
`else
          r_all_aligned <= (w_lost == '0);
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign aligner_reset_o = r_aligner_reset;
  assign all_aligned_o   = r_all_aligned;
  assign busy_o          = r_busy;
  assign fail_mask_o     = r_fail;
  assign realign_cnt_o   = r_realign_cnt;
  assign state_o         = r_state;

endmodule
